// File: rtl/rv32i_pkg.sv
// Shared register-file definitions: data width, register addressing and the write-back request.
package rv32i_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wd;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO with occupancy count; head data is visible combinationally.
// Push is ignored when full and pop is ignored when empty, so callers may gate loosely.
module wb_fifo #(
    parameter  int WIDTH = 37,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign do_push    = push_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end
endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: ALU writes win same-cycle, load returns drain from a FIFO
// (>=1 cycle latency); lsu_ready drops only when the FIFO is full. Tracks pending loads.
module reg_wb_arbiter
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         areset,
    input  logic                         alu_valid,
    input  logic [REG_ADDR_W-1:0]        alu_rd,
    input  logic [XLEN-1:0]              alu_wd,
    input  logic                         lsu_valid,
    output logic                         lsu_ready,
    input  logic [REG_ADDR_W-1:0]        lsu_rd,
    input  logic [XLEN-1:0]              lsu_wd,
    input  logic                         iss_valid,
    input  logic [REG_ADDR_W-1:0]        iss_rd,
    input  logic [REG_ADDR_W-1:0]        rs1,
    input  logic [REG_ADDR_W-1:0]        rs2,
    output logic                         hazard,
    output logic [NUM_REGS-1:0]          pending,
    output logic [$clog2(DEPTH):0]       fifo_count,
    output logic                         waw_err,
    output logic                         WE3,
    output logic [REG_ADDR_W-1:0]        A3,
    output logic [XLEN-1:0]              WD3
);
    wb_req_t             head;
    wb_req_t             push_req;
    logic                fifo_full, fifo_empty;
    logic                alu_wr, lsu_push, fifo_pop, iss_set;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                waw_q, waw_d;

    assign lsu_ready = ~fifo_full;
    assign alu_wr    = alu_valid & (alu_rd != '0);
    assign lsu_push  = lsu_valid & lsu_ready & (lsu_rd != '0);
    assign fifo_pop  = ~alu_wr & ~fifo_empty;
    assign iss_set   = iss_valid & (iss_rd != '0);
    assign push_req  = '{rd: lsu_rd, wd: lsu_wd};

    wb_fifo #(
        .WIDTH ($bits(wb_req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .areset     (areset),
        .push_i     (lsu_push),
        .push_dat_i (push_req),
        .pop_i      (fifo_pop),
        .head_dat_o (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    always_comb begin
        WE3 = 1'b0;
        A3  = '0;
        WD3 = '0;
        if (alu_wr) begin
            WE3 = 1'b1;
            A3  = alu_rd;
            WD3 = alu_wd;
        end else if (!fifo_empty) begin
            WE3 = 1'b1;
            A3  = head.rd;
            WD3 = head.wd;
        end
    end

    // A new issue to the register being retired this cycle must stay pending.
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop) pending_d[head.rd] = 1'b0;
        if (iss_set)  pending_d[iss_rd]  = 1'b1;
        pending_d[0] = 1'b0;
    end

    assign waw_d = (alu_wr & pending_q[alu_rd]) | (iss_set & pending_q[iss_rd]);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            pending_q <= '0;
            waw_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            waw_q     <= waw_d;
        end
    end

    assign pending = pending_q;
    assign waw_err = waw_q;
    assign hazard  = ((rs1 != '0) & pending_q[rs1]) | ((rs2 != '0) & pending_q[rs2]);
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Randomized and directed bench for reg_wb_arbiter against a queue-based reference model.
module tb_reg_wb_arbiter;
    import rv32i_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          areset;
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_wd;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [4:0]    lsu_rd;
    logic [31:0]   lsu_wd;
    logic          iss_valid;
    logic [4:0]    iss_rd;
    logic [4:0]    rs1, rs2;
    logic          hazard;
    logic [31:0]   pending;
    logic [CW-1:0] fifo_count;
    logic          waw_err;
    logic          WE3;
    logic [4:0]    A3;
    logic [31:0]   WD3;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .areset     (areset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_wd     (alu_wd),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_wd     (lsu_wd),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .hazard     (hazard),
        .pending    (pending),
        .fifo_count (fifo_count),
        .waw_err    (waw_err),
        .WE3        (WE3),
        .A3         (A3),
        .WD3        (WD3)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: outstanding load returns in arrival order plus a pending flag per register.
    wb_req_t    m_q[$];
    bit         m_pend[32];
    bit         m_waw;
    logic       obs_we;
    logic [4:0] obs_a3;

    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        v = '0;
        for (int r = 1; r < 32; r++) v[r] = m_pend[r];
        return v;
    endfunction

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_wd = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_wd = 0;
        iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic step();
        bit          alu_w, ready, exp_haz, waw_n, exp_we;
        logic [4:0]  exp_a3;
        logic [31:0] exp_wd;
        wb_req_t     h;
        @(negedge clk);
        alu_w   = alu_valid && alu_rd != 0;
        ready   = m_q.size() < DEPTH;
        exp_haz = (rs1 != 0 && m_pend[rs1]) || (rs2 != 0 && m_pend[rs2]);
        exp_we = 0; exp_a3 = 0; exp_wd = 0;
        if (alu_w) begin
            exp_we = 1; exp_a3 = alu_rd; exp_wd = alu_wd;
        end else if (m_q.size() > 0) begin
            exp_we = 1; exp_a3 = m_q[0].rd; exp_wd = m_q[0].wd;
        end
        check_eq("lsu_ready",  lsu_ready,  ready);
        check_eq("fifo_count", fifo_count, m_q.size());
        check_eq("pending",    pending,    pend_vec());
        check_eq("hazard",     hazard,     exp_haz);
        check_eq("waw_err",    waw_err,    m_waw);
        check_eq("WE3",        WE3,        exp_we);
        check_eq("A3",         A3,         exp_a3);
        check_eq("WD3",        WD3,        exp_wd);
        obs_we = WE3;
        obs_a3 = A3;
        waw_n = (alu_w && m_pend[alu_rd]) || (iss_valid && iss_rd != 0 && m_pend[iss_rd]);
        if (!alu_w && m_q.size() > 0) begin
            h = m_q.pop_front();
            m_pend[h.rd] = 0;
        end
        if (lsu_valid && ready && lsu_rd != 0) m_q.push_back(wb_req_t'{rd: lsu_rd, wd: lsu_wd});
        if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1;
        m_waw = waw_n;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1;
        #1;
        m_q.delete();
        foreach (m_pend[r]) m_pend[r] = 0;
        m_waw = 0;
        check_eq("rst_WE3",        WE3,        0);
        check_eq("rst_A3",         A3,         0);
        check_eq("rst_WD3",        WD3,        0);
        check_eq("rst_lsu_ready",  lsu_ready,  1);
        check_eq("rst_fifo_count", fifo_count, 0);
        check_eq("rst_pending",    pending,    0);
        check_eq("rst_waw",        waw_err,    0);
        check_eq("rst_hazard",     hazard,     0);
        @(posedge clk);
        #1;
        areset = 0;
    endtask

    initial begin
        int         nxt;
        bit         rdy;
        logic [4:0] commits[$];

        idle();
        areset = 1;
        #2;
        do_reset();

        // 1: three loads queued behind ALU traffic, then reset mid-stream
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_rd = 1; alu_wd = $urandom;
            lsu_valid = 1; lsu_rd = 5'(9 + i); lsu_wd = $urandom;
            iss_valid = 1; iss_rd = 5'(20 + i);
            step();
        end
        idle();
        do_reset();

        // 2: ALU write is visible in the same cycle
        alu_valid = 1; alu_rd = 5; alu_wd = 32'hDEADBEEF;
        step();
        idle();
        step();

        // 3: issue, load return, commit and scoreboard clear
        iss_valid = 1; iss_rd = 7;
        step();
        idle();
        step();
        lsu_valid = 1; lsu_rd = 7; lsu_wd = 32'h1234;
        step();
        idle();
        step();
        step();

        // 4: ALU hogs the port while the LSU fills the FIFO; commits must keep arrival order
        nxt = 8;
        for (int cyc = 0; cyc < 40 && commits.size() < 5; cyc++) begin
            alu_valid = (cyc < 6); alu_rd = 5'(cyc + 1); alu_wd = $urandom;
            lsu_valid = (nxt <= 12); lsu_rd = 5'(nxt); lsu_wd = 32'(nxt) << 4;
            rdy = m_q.size() < DEPTH;
            step();
            if (lsu_valid && rdy) nxt++;
            if (obs_we && !alu_valid) commits.push_back(obs_a3);
        end
        idle();
        check_eq("t4_commit_cnt", commits.size(), 5);
        for (int i = 0; i < 5; i++)
            check_eq("t4_commit_order", (i < commits.size()) ? commits[i] : 5'd0, 8 + i);

        // 5: writes and returns addressed to x0
        alu_valid = 1; alu_rd = 0; alu_wd = 32'hFFFF_FFFF;
        step();
        idle();
        lsu_valid = 1; lsu_rd = 0; lsu_wd = 32'hCAFE;
        step();
        idle();
        step();

        // 6: hazard on a pending register, then an ALU write-after-write
        iss_valid = 1; iss_rd = 3;
        step();
        idle(); rs1 = 3;
        step();
        rs1 = 0; rs2 = 3;
        step();
        idle(); alu_valid = 1; alu_rd = 3; alu_wd = 32'h55;
        step();
        idle();
        step();
        step();
        do_reset();

        // Random traffic with a reset in the middle
        for (int i = 0; i < 400; i++) begin
            alu_valid = ($urandom_range(0, 99) < 40);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_wd    = $urandom;
            lsu_valid = ($urandom_range(0, 99) < 50);
            lsu_rd    = 5'($urandom_range(0, 31));
            lsu_wd    = $urandom;
            iss_valid = ($urandom_range(0, 99) < 25);
            iss_rd    = 5'($urandom_range(0, 31));
            rs1       = 5'($urandom_range(0, 31));
            rs2       = 5'($urandom_range(0, 31));
            step();
            if (i == 200) begin
                idle();
                do_reset();
            end
        end
        idle();
        for (int i = 0; i < 6; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
